ahb_default_sub: RTL and testbench
==================================

Name: ahb_default_sub

Overview:
- AHB-Lite default subordinate in the uncore. It answers every transfer that decodes to no region: the unmapped-hole select from the address decoder.
- It is the bus-side counterpart of the core PMA fault check. Any access that escapes PMA checking, such as debug or an external manager, gets a protocol-correct two-cycle ERROR response.
- It logs the first faulting access and counts all faults for software and debug visibility.

Parameters:
- P, cvw_t, core configuration. Uses P.PA_BITS for address width and P.AHBW for data width.
- CNT_BITS, 8, width of the saturating error counter.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- HSELNone  in  1  no region selected for the current address phase
- HADDR  in  P.PA_BITS  address-phase address
- HTRANS  in  2  transfer type: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
- HWRITE  in  1  address-phase write flag
- HSIZE  in  3  address-phase size
- HREADY  in  1  bus-wide ready, from the mux
- HREADYOUT  out  1  this subordinate's ready
- HRESP  out  1  1 = ERROR
- HRDATA  out  P.AHBW  always 0
- ErrClear  in  1  clears the log and the counter
- ErrValid  out  1  sticky; the log holds a fault
- ErrAddr  out  P.PA_BITS  address of the first logged fault
- ErrWrite  out  1  HWRITE of the logged fault
- ErrSize  out  3  HSIZE of the logged fault
- ErrCount  out  CNT_BITS  number of faults, saturating

Behaviour:
- Clock and reset: one clock domain; reset is synchronous and active-high.
- Reset values: state = IDLE, HREADYOUT = 1, HRESP = 0, HRDATA = 0, ErrValid = 0, ErrAddr = 0, ErrWrite = 0, ErrSize = 0, ErrCount = 0.
- Accept condition: Accept = HSELNone & HREADY & HTRANS[1]. It is evaluated on the clock edge.
- IDLE/BUSY transfers (HTRANS[1] = 0), or HREADY = 0, are not accepted. They get a zero-wait OKAY and cause no state change.
- States:
  - IDLE: HREADYOUT = 1, HRESP = 0. On Accept, go to ERR1.
  - ERR1: HREADYOUT = 0, HRESP = 1. Unconditionally go to ERR2 next cycle. Address-phase inputs are ignored, because HREADY is low.
  - ERR2: HREADYOUT = 1, HRESP = 1. On Accept, go to ERR1 for back-to-back errors. Otherwise go to IDLE.
- Outputs are registered and derived from state. Latency from accepted address phase to the first ERROR cycle is 1 cycle. The response is always exactly 2 cycles, with no extra wait states.
- A manager that cancels its next transfer during ERR1 (HTRANS changed to IDLE) needs no special handling: nothing is sampled while HREADY = 0.
- Logging, in the Accept cycle:
  - ErrCount increments, saturating at all ones and never wrapping.
  - If ErrValid = 0: capture HADDR, HWRITE, HSIZE and set ErrValid.
  - If ErrValid = 1: the log is unchanged (first-fault-wins).
- ErrClear alone: the next cycle has ErrValid = 0 and ErrCount = 0. ErrAddr, ErrWrite and ErrSize are cleared to 0.
- ErrClear in the same cycle as Accept: the clear applies first, then the new fault is logged. Result: ErrValid = 1, captured fields are the new ones, ErrCount = 1.
- Reset mid-response (in ERR1 or ERR2): return to IDLE, with HREADYOUT = 1 and HRESP = 0 the next cycle. The log and counter are cleared.
- HRDATA is constant 0 in every state, including during read errors.

Decomposition:
- Shared package: HTRANS encodings (AHB_IDLE, AHB_BUSY, AHB_NONSEQ, AHB_SEQ), if not already present alongside cvw_t.
- Local to the block: the state enum {IDLE, ERR1, ERR2}.
- One sub-module: satcounter (parameter WIDTH; inputs clk, reset, clr, inc; output q, with clr having priority over inc).
- The error log and the FSM stay inline.

Test Plan:
- NONSEQ read at HADDR = 0x0000_0004, HSEL = 1, HREADY = 1:
  - Cycle +1: HREADYOUT = 0, HRESP = 1.
  - Cycle +2: HREADYOUT = 1, HRESP = 1.
  - Cycle +3: idle OKAY.
  - Log: ErrValid = 1, ErrAddr = 0x4, ErrWrite = 0, ErrSize = 2, ErrCount = 1.
- IDLE and BUSY transfers with HSEL = 1 for 5 cycles -> HREADYOUT stays 1, HRESP stays 0, ErrCount = 0.
- Back-to-back: write at 0x10 (HSIZE 3), then a new NONSEQ accepted during ERR2 -> response sequence ERR1, ERR2, ERR1, ERR2; ErrAddr = 0x10, ErrWrite = 1, ErrCount = 2.
- Saturation: with CNT_BITS = 2, run 5 faulting transfers -> ErrCount reads 1, 2, 3, 3, 3; ErrAddr remains the first fault's address.
- ErrClear asserted in the same cycle as an Accept at 0x20 -> ErrValid = 1, ErrAddr = 0x20, ErrCount = 1. ErrClear alone the following cycle -> ErrValid = 0, ErrCount = 0.
- Reset asserted during ERR1 -> next cycle state IDLE, HREADYOUT = 1, HRESP = 0, ErrValid = 0; a new NONSEQ afterwards produces a full 2-cycle ERROR.

Source files
------------

// File: rtl/ahb_default_sub_pkg.sv
// Shared types for the AHB default subordinate: core configuration and
// HTRANS encodings.
package ahb_default_sub_pkg;

    // Core configuration slice used by the uncore AHB blocks
    typedef struct packed {
        int unsigned PA_BITS;
        int unsigned AHBW;
    } cvw_t;

    localparam cvw_t CVW_DEFAULT = '{PA_BITS: 32, AHBW: 32};

    // AHB-Lite transfer types
    typedef enum logic [1:0] {
        AHB_IDLE   = 2'b00,
        AHB_BUSY   = 2'b01,
        AHB_NONSEQ = 2'b10,
        AHB_SEQ    = 2'b11
    } htrans_t;

endpackage

// File: rtl/ahb_default_sub_satcounter.sv
// Saturating up-counter with synchronous clear.
module satcounter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] q
);

    // Clear wins over the old value; an increment in the same cycle counts
    // from zero, so a simultaneous clear and increment leaves exactly 1.
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (clr) begin
            q <= WIDTH'(inc);
        end else if (inc && (q != '1)) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/ahb_default_sub.sv
// AHB-Lite default subordinate: two-cycle ERROR response for unmapped
// accesses, first-fault log and saturating fault counter.
module ahb_default_sub
    import ahb_default_sub_pkg::*;
#(
    parameter cvw_t P        = CVW_DEFAULT,
    parameter int   CNT_BITS = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  HSELNone,
    input  logic [P.PA_BITS-1:0]  HADDR,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic [P.AHBW-1:0]     HRDATA,
    input  logic                  ErrClear,
    output logic                  ErrValid,
    output logic [P.PA_BITS-1:0]  ErrAddr,
    output logic                  ErrWrite,
    output logic [2:0]            ErrSize,
    output logic [CNT_BITS-1:0]   ErrCount
);

    typedef enum logic [1:0] {
        IDLE,
        ERR1,
        ERR2
    } state_t;

    state_t state;
    state_t stateNext;
    logic   accept;

    assign accept = HSELNone & HREADY & HTRANS[1];
    assign HRDATA = '0;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state logic and state-decoded response outputs
    always_comb begin
        stateNext = state;
        HREADYOUT = 1'b1;
        HRESP     = 1'b0;
        case (state)
            IDLE: begin
                if (accept) stateNext = ERR1;
            end
            ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = 1'b1;
                stateNext = ERR2;
            end
            ERR2: begin
                HRESP     = 1'b1;
                stateNext = accept ? ERR1 : IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    // First-fault log; a clear in the accept cycle makes the new fault the first
    always_ff @(posedge clk) begin
        if (reset) begin
            ErrValid <= 1'b0;
            ErrAddr  <= '0;
            ErrWrite <= 1'b0;
            ErrSize  <= '0;
        end else if (accept && (!ErrValid || ErrClear)) begin
            ErrValid <= 1'b1;
            ErrAddr  <= HADDR;
            ErrWrite <= HWRITE;
            ErrSize  <= HSIZE;
        end else if (ErrClear && !accept) begin
            ErrValid <= 1'b0;
            ErrAddr  <= '0;
            ErrWrite <= 1'b0;
            ErrSize  <= '0;
        end
    end

    satcounter #(
        .WIDTH(CNT_BITS)
    ) errCounter (
        .clk  (clk),
        .reset(reset),
        .clr  (ErrClear),
        .inc  (accept),
        .q    (ErrCount)
    );

endmodule

// File: tb/tb_ahb_default_sub.sv
// Randomized self-checking bench for ahb_default_sub against a transaction-level model.
module tb_ahb_default_sub;
    import ahb_default_sub_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        hselNone;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic        hready;
    logic        errClear;

    logic        hreadyOut, hresp, errValid, errWrite;
    logic [31:0] hrdata, errAddr;
    logic [2:0]  errSize;
    logic [7:0]  errCount;

    logic        satReadyOut, satResp, satValid, satWrite;
    logic [31:0] satRdata, satAddr;
    logic [2:0]  satSize;
    logic [1:0]  satCount;

    int nChecks = 0;
    int nFails  = 0;

    // Model: cycles of ERROR response still owed, plus the software-visible log
    int          mRespLeft;
    logic        mValid;
    logic [31:0] mAddr;
    logic        mWrite;
    logic [2:0]  mSize;
    int          mCnt8;
    int          mCnt2;

    always #5 clk = ~clk;

    ahb_default_sub dut (
        .clk(clk), .reset(reset), .HSELNone(hselNone), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HREADY(hready), .HREADYOUT(hreadyOut),
        .HRESP(hresp), .HRDATA(hrdata), .ErrClear(errClear), .ErrValid(errValid),
        .ErrAddr(errAddr), .ErrWrite(errWrite), .ErrSize(errSize), .ErrCount(errCount)
    );

    ahb_default_sub #(.CNT_BITS(2)) dutSat (
        .clk(clk), .reset(reset), .HSELNone(hselNone), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HREADY(hready), .HREADYOUT(satReadyOut),
        .HRESP(satResp), .HRDATA(satRdata), .ErrClear(errClear), .ErrValid(satValid),
        .ErrAddr(satAddr), .ErrWrite(satWrite), .ErrSize(satSize), .ErrCount(satCount)
    );

    task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nChecks++;
        if (obs !== exp) begin
            nFails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic checkOutputs();
        logic expReady, expResp;
        expReady = (mRespLeft != 2);
        expResp  = (mRespLeft != 0);
        checkVal("hreadyout", 64'(hreadyOut), 64'(expReady));
        checkVal("hresp",     64'(hresp),     64'(expResp));
        checkVal("hrdata",    64'(hrdata),    64'(0));
        checkVal("errvalid",  64'(errValid),  64'(mValid));
        checkVal("erraddr",   64'(errAddr),   64'(mAddr));
        checkVal("errwrite",  64'(errWrite),  64'(mWrite));
        checkVal("errsize",   64'(errSize),   64'(mSize));
        checkVal("errcount",  64'(errCount),  64'(mCnt8));
        checkVal("sat_hreadyout", 64'(satReadyOut), 64'(expReady));
        checkVal("sat_hresp",     64'(satResp),     64'(expResp));
        checkVal("sat_errcount",  64'(satCount),    64'(mCnt2));
        checkVal("sat_erraddr",   64'(satAddr),     64'(mAddr));
    endtask

    task automatic modelUpdate();
        logic acc;
        if (reset) begin
            mRespLeft = 0; mValid = 1'b0; mAddr = '0; mWrite = 1'b0; mSize = '0;
            mCnt8 = 0; mCnt2 = 0;
        end else begin
            acc = hselNone & hready & htrans[1];
            if (mRespLeft == 2) mRespLeft = 1;
            else                mRespLeft = acc ? 2 : 0;
            if (errClear) begin
                mValid = 1'b0; mAddr = '0; mWrite = 1'b0; mSize = '0;
                mCnt8 = 0; mCnt2 = 0;
            end
            if (acc) begin
                mCnt8 = (mCnt8 < 255) ? mCnt8 + 1 : 255;
                mCnt2 = (mCnt2 < 3) ? mCnt2 + 1 : 3;
                if (!mValid) begin
                    mValid = 1'b1; mAddr = haddr; mWrite = hwrite; mSize = hsize;
                end
            end
        end
    endtask

    // One bus cycle: check outputs mid-cycle, drive inputs, advance the model on the edge.
    // HREADY is held low while this subordinate is stalling the bus.
    task automatic step(input logic sel, input logic [31:0] addr, input logic [1:0] trans,
                        input logic wr, input logic [2:0] sz, input logic rdy,
                        input logic clr, input logic rst);
        @(negedge clk);
        checkOutputs();
        hselNone = sel; haddr = addr; htrans = trans; hwrite = wr; hsize = sz;
        hready   = (mRespLeft == 2) ? 1'b0 : rdy;
        errClear = clr; reset = rst;
        @(posedge clk);
        modelUpdate();
    endtask

    task automatic idleStep();
        step(1'b0, 32'h0, AHB_IDLE, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic fault(input logic [31:0] addr, input logic wr, input logic [2:0] sz);
        step(1'b1, addr, AHB_NONSEQ, wr, sz, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        hselNone = 0; haddr = 0; htrans = AHB_IDLE; hwrite = 0; hsize = 0;
        hready = 1; errClear = 0; reset = 1;
        mRespLeft = 0; mValid = 0; mAddr = 0; mWrite = 0; mSize = 0; mCnt8 = 0; mCnt2 = 0;

        // Reset, then reset-state outputs
        step(1'b0, 32'h0, AHB_IDLE, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 32'h0, AHB_IDLE, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1);
        idleStep();

        // Single NONSEQ read at 0x4
        fault(32'h4, 1'b0, 3'd2);
        #1 checkVal("read_err1_ready", 64'(hreadyOut), 64'(0));
        checkVal("read_err1_resp", 64'(hresp), 64'(1));
        idleStep();
        #1 checkVal("read_err2_ready", 64'(hreadyOut), 64'(1));
        checkVal("read_err2_resp", 64'(hresp), 64'(1));
        idleStep();
        #1 checkVal("read_done_resp", 64'(hresp), 64'(0));
        checkVal("read_log_addr", 64'(errAddr), 64'h4);
        checkVal("read_log_size", 64'(errSize), 64'(2));
        checkVal("read_log_count", 64'(errCount), 64'(1));

        // Clear, then IDLE/BUSY with select high are never errored
        step(1'b0, 32'h0, AHB_IDLE, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++)
            step(1'b1, $urandom, (i % 2) ? AHB_BUSY : AHB_IDLE, 1'b0, 3'd1, 1'b1, 1'b0, 1'b0);
        idleStep();
        #1 checkVal("idlebusy_count", 64'(errCount), 64'(0));

        // Back-to-back: write at 0x10, second NONSEQ accepted during ERR2
        fault(32'h10, 1'b1, 3'd3);
        step(1'b1, 32'h30, AHB_NONSEQ, 1'b0, 3'd2, 1'b1, 1'b0, 1'b0);
        fault(32'h30, 1'b0, 3'd2);
        #1 checkVal("b2b_err1_again", 64'(hreadyOut), 64'(0));
        idleStep();
        idleStep();
        #1 checkVal("b2b_addr", 64'(errAddr), 64'h10);
        checkVal("b2b_write", 64'(errWrite), 64'(1));
        checkVal("b2b_count", 64'(errCount), 64'(2));

        // Saturation on the 2-bit counter
        step(1'b0, 32'h0, AHB_IDLE, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            fault(32'h100 + 32'(i * 4), 1'b0, 3'd0);
            #1 checkVal("sat_count", 64'(satCount), 64'((i < 3) ? i + 1 : 3));
            idleStep();
            idleStep();
        end
        #1 checkVal("sat_first_addr", 64'(satAddr), 64'h100);

        // Clear coincident with accept, then clear alone
        step(1'b1, 32'h20, AHB_NONSEQ, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0);
        #1 checkVal("clracc_valid", 64'(errValid), 64'(1));
        checkVal("clracc_addr", 64'(errAddr), 64'h20);
        checkVal("clracc_count", 64'(errCount), 64'(1));
        step(1'b0, 32'h0, AHB_IDLE, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0);
        #1 checkVal("clr_valid", 64'(errValid), 64'(0));
        checkVal("clr_count", 64'(errCount), 64'(0));
        idleStep();

        // Reset during ERR1, then a fresh full error response
        fault(32'h44, 1'b1, 3'd1);
        step(1'b0, 32'h0, AHB_IDLE, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1);
        #1 checkVal("rst_err1_ready", 64'(hreadyOut), 64'(1));
        checkVal("rst_err1_resp", 64'(hresp), 64'(0));
        checkVal("rst_err1_valid", 64'(errValid), 64'(0));
        fault(32'h48, 1'b0, 3'd2);
        idleStep();
        idleStep();

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 1) == 1), $urandom, 2'($urandom_range(0, 3)),
                 ($urandom_range(0, 1) == 1), 3'($urandom_range(0, 7)),
                 ($urandom_range(0, 7) != 0), ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 63) == 0));
        end
        idleStep();

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
